// File: rtl/constraint_sample_ctrl_if.sv
// Sampler <-> requester/checker bundle: request controls, candidate/check pair, accepted-sample handshake, status.
// The requester side (master) drives controls, chk_ok and out_ready; the sampler (slave) drives the rest.
interface constraint_sample_ctrl_if #(
  parameter int CAND_W = 64
);
  logic              start;
  logic              seed_load;
  logic [31:0]       seed;
  logic [CAND_W-1:0] cand;
  logic              chk_ok;
  logic              out_valid;
  logic              out_ready;
  logic [CAND_W-1:0] out_data;
  logic              busy;
  logic              fail;
  logic [15:0]       tries;

  modport master (
    output start, seed_load, seed, chk_ok, out_ready,
    input  cand, out_valid, out_data, busy, fail, tries
  );

  modport slave (
    input  start, seed_load, seed, chk_ok, out_ready,
    output cand, out_valid, out_data, busy, fail, tries
  );
endinterface

// File: rtl/constraint_sample_ctrl.sv
// Rejection sampler: LFSR candidates retried until chk_ok, W+CHK_LAT cycles per attempt.
// Accepted sample is held in HOLD (out_valid) until out_ready; no other stage stalls.
module constraint_sample_ctrl #(
  parameter int CAND_W    = 64,
  parameter int MAX_TRIES = 1024,
  parameter int CHK_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  constraint_sample_ctrl_if.slave  bus
);
  localparam int          W        = CAND_W / 32;
  localparam logic [31:0] TAPS     = 32'h80200003;
  localparam logic [5:0]  GEN_LAST = 6'(W - 1);
  localparam logic [5:0]  LAT_LAST = 6'(CHK_LAT - 1);
  localparam logic [15:0] TRY_MAX  = 16'(MAX_TRIES);

  typedef enum logic [2:0] {ST_IDLE, ST_GEN, ST_WAIT, ST_HOLD, ST_FAIL} state_t;

  state_t            state;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_nxt;
  logic [CAND_W-1:0] cand;
  logic [CAND_W-1:0] cand_nxt;
  logic [CAND_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              fail;
  logic [15:0]       tries;
  logic [5:0]        cnt;

  always_comb begin
    lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
  end

  // Newest LFSR word enters at bit 0; a single-word candidate is just the word.
  generate
    if (W == 1) begin : g_one_word
      assign cand_nxt = lfsr_nxt;
    end else begin : g_multi_word
      assign cand_nxt = {cand[CAND_W-33:0], lfsr_nxt};
    end
  endgenerate

  assign bus.cand      = cand;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.fail      = fail;
  assign bus.tries     = tries;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lfsr      <= 32'h1;
      cand      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      fail      <= 1'b0;
      tries     <= 16'h0;
      cnt       <= 6'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.seed_load) begin
            lfsr <= (bus.seed == 32'h0) ? 32'h1 : bus.seed;
          end else if (bus.start) begin
            tries <= 16'h0;
            cnt   <= 6'h0;
            busy  <= 1'b1;
            state <= ST_GEN;
          end
        end
        ST_GEN: begin
          lfsr <= lfsr_nxt;
          cand <= cand_nxt;
          if (cnt == GEN_LAST) begin
            cnt   <= 6'h0;
            tries <= tries + 16'd1;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_WAIT: begin
          // chk_ok is only meaningful once the checker has seen cand for CHK_LAT cycles.
          if (cnt == LAT_LAST) begin
            cnt <= 6'h0;
            if (bus.chk_ok) begin
              out_data  <= cand;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end else if (tries == TRY_MAX) begin
              fail  <= 1'b1;
              state <= ST_FAIL;
            end else begin
              state <= ST_GEN;
            end
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_FAIL: begin
          fail  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_constraint_sample_ctrl.sv
// Two sampler instances: 32-bit/CHK_LAT=1 for directed cases, 64-bit/CHK_LAT=2/MAX_TRIES=4 against a cycle-count reference model.
module tb_constraint_sample_ctrl;
  localparam int WB  = 2;
  localparam int LB  = 2;
  localparam int MTB = 4;
  localparam int PB  = WB + LB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] m_lfsr_b = 32'h1;

  constraint_sample_ctrl_if #(.CAND_W(32)) a_if ();
  constraint_sample_ctrl_if #(.CAND_W(64)) b_if ();

  constraint_sample_ctrl #(.CAND_W(32), .MAX_TRIES(1024), .CHK_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );
  constraint_sample_ctrl #(.CAND_W(64), .MAX_TRIES(MTB), .CHK_LAT(LB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Galois right-shift LFSR written from its polynomial taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ ((32'h1 << 31) | (32'h1 << 21) | 32'h3);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_first_run(input string tag);
    a_if.chk_ok = 1'b1;
    a_if.start  = 1'b1;
    cyc();
    a_if.start = 1'b0;
    check_eq({tag, "_busy0"}, 64'(a_if.busy), 64'd1);
    check_eq({tag, "_vld0"}, 64'(a_if.out_valid), 64'd0);
    cyc();
    check_eq({tag, "_cand"}, 64'(a_if.cand), 64'h80200003);
    check_eq({tag, "_tries"}, 64'(a_if.tries), 64'd1);
    check_eq({tag, "_vld1"}, 64'(a_if.out_valid), 64'd0);
    cyc();
    check_eq({tag, "_vld2"}, 64'(a_if.out_valid), 64'd1);
    check_eq({tag, "_data"}, 64'(a_if.out_data), 64'h80200003);
  endtask

  task automatic a_accept(input string tag);
    a_if.out_ready = 1'b1;
    cyc();
    a_if.out_ready = 1'b0;
    check_eq({tag, "_vld_drop"}, 64'(a_if.out_valid), 64'd0);
    check_eq({tag, "_idle"}, 64'(a_if.busy), 64'd0);
  endtask

  task automatic b_seed(input logic [31:0] s);
    b_if.seed_load = 1'b1;
    b_if.seed      = s;
    b_if.start     = 1'($urandom);
    cyc();
    b_if.seed_load = 1'b0;
    b_if.start     = 1'b0;
    m_lfsr_b = (s == 32'h0) ? 32'h1 : s;
    check_eq("b_seed_busy", 64'(b_if.busy), 64'd0);
  endtask

  // p_pass: attempt on which chk_ok is 1; beyond MTB means every attempt is rejected.
  task automatic run_b(input int p_pass);
    int          n_att;
    bit          pass;
    int          t_end;
    int          k_now;
    bit          rdy_prev;
    bit          done;
    logic [63:0] c;
    logic [63:0] exp_c [$];
    n_att = (p_pass > MTB) ? MTB : p_pass;
    pass  = (p_pass <= MTB);
    t_end = n_att * PB;
    for (int k = 0; k < n_att; k++) begin
      c = 64'h0;
      for (int j = 0; j < WB; j++) begin
        m_lfsr_b = lfsr_step(m_lfsr_b);
        c = {c[31:0], m_lfsr_b};
      end
      exp_c.push_back(c);
    end
    b_if.start     = 1'b1;
    b_if.chk_ok    = 1'($urandom);
    b_if.out_ready = 1'($urandom);
    cyc();
    for (int t = 1; t <= t_end; t++) begin
      b_if.start     = 1'($urandom);
      b_if.seed_load = 1'($urandom);
      b_if.seed      = $urandom;
      b_if.out_ready = 1'($urandom);
      if (t % PB == 0) b_if.chk_ok = pass && (t / PB == p_pass);
      else             b_if.chk_ok = 1'($urandom);
      cyc();
      k_now = 0;
      for (int k = 1; k <= n_att; k++)
        if ((k - 1) * PB + WB <= t) k_now = k;
      check_eq("b_tries", 64'(b_if.tries), 64'(k_now));
      if (k_now > 0 && t - (k_now - 1) * PB <= PB)
        check_eq("b_cand", b_if.cand, exp_c[k_now-1]);
      if (t < t_end) begin
        check_eq("b_busy", 64'(b_if.busy), 64'd1);
        check_eq("b_vld_early", 64'(b_if.out_valid), 64'd0);
        check_eq("b_fail_early", 64'(b_if.fail), 64'd0);
      end
    end
    check_eq("b_end_vld", 64'(b_if.out_valid), 64'(pass));
    check_eq("b_end_fail", 64'(b_if.fail), 64'(!pass));
    check_eq("b_end_busy", 64'(b_if.busy), 64'd1);
    if (pass) begin
      check_eq("b_data", b_if.out_data, exp_c[n_att-1]);
      done = 1'b0;
      for (int h = 0; h < 20 && !done; h++) begin
        b_if.out_ready = (h >= 12) ? 1'b1 : ($urandom_range(0, 3) == 0);
        b_if.start     = 1'($urandom);
        b_if.seed_load = 1'($urandom);
        b_if.chk_ok    = 1'($urandom);
        rdy_prev = b_if.out_ready;
        cyc();
        if (rdy_prev) begin
          check_eq("b_hold_drop", 64'(b_if.out_valid), 64'd0);
          check_eq("b_hold_idle", 64'(b_if.busy), 64'd0);
          done = 1'b1;
        end else begin
          check_eq("b_hold_vld", 64'(b_if.out_valid), 64'd1);
          check_eq("b_hold_data", b_if.out_data, exp_c[n_att-1]);
        end
      end
    end else begin
      b_if.start     = 1'($urandom);
      b_if.seed_load = 1'($urandom);
      cyc();
      check_eq("b_fail_pulse", 64'(b_if.fail), 64'd0);
      check_eq("b_fail_idle", 64'(b_if.busy), 64'd0);
      check_eq("b_fail_vld", 64'(b_if.out_valid), 64'd0);
    end
    b_if.start     = 1'b0;
    b_if.seed_load = 1'b0;
    b_if.out_ready = 1'b0;
    cyc();
    check_eq("b_post_busy", 64'(b_if.busy), 64'd0);
    check_eq("b_post_tries", 64'(b_if.tries), 64'(n_att));
    check_eq("b_post_vld", 64'(b_if.out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s;
    a_if.start = 1'b0; a_if.seed_load = 1'b0; a_if.seed = 32'h0;
    a_if.chk_ok = 1'b0; a_if.out_ready = 1'b0;
    b_if.start = 1'b0; b_if.seed_load = 1'b0; b_if.seed = 32'h0;
    b_if.chk_ok = 1'b0; b_if.out_ready = 1'b0;

    #2;
    check_eq("rst_busy", 64'(a_if.busy), 64'd0);
    check_eq("rst_vld", 64'(a_if.out_valid), 64'd0);
    check_eq("rst_fail", 64'(a_if.fail), 64'd0);
    check_eq("rst_tries", 64'(a_if.tries), 64'd0);
    check_eq("rst_cand", 64'(a_if.cand), 64'd0);
    check_eq("rst_data", 64'(a_if.out_data), 64'd0);
    check_eq("rst_b_cand", b_if.cand, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    a_first_run("first");

    // Backpressure in HOLD with start pulses that must be ignored.
    for (int i = 0; i < 10; i++) begin
      a_if.start = (i % 2 == 0);
      cyc();
      check_eq("hold_vld", 64'(a_if.out_valid), 64'd1);
      check_eq("hold_data", 64'(a_if.out_data), 64'h80200003);
    end
    a_if.start = 1'b0;
    a_accept("hold");
    cyc();
    check_eq("tries_kept", 64'(a_if.tries), 64'd1);

    // seed 0 with start in the same cycle: reseed to 1, no request.
    a_if.seed_load = 1'b1; a_if.seed = 32'h0; a_if.start = 1'b1;
    cyc();
    a_if.seed_load = 1'b0; a_if.start = 1'b0;
    check_eq("seed0_busy", 64'(a_if.busy), 64'd0);
    cyc();
    check_eq("seed0_busy2", 64'(a_if.busy), 64'd0);
    a_first_run("seed0");
    a_accept("seed0");

    // Non-zero seed, then the first candidate is one LFSR step past it.
    s = $urandom | 32'h1;
    a_if.seed_load = 1'b1; a_if.seed = s;
    cyc();
    a_if.seed_load = 1'b0;
    a_if.chk_ok = 1'b1; a_if.start = 1'b1;
    cyc();
    a_if.start = 1'b0;
    cyc();
    check_eq("seed_cand", 64'(a_if.cand), 64'(lfsr_step(s)));
    cyc();
    check_eq("seed_vld", 64'(a_if.out_valid), 64'd1);
    a_accept("seed");

    // Reset in WAIT abandons the request.
    a_if.chk_ok = 1'b0; a_if.start = 1'b1;
    cyc();
    a_if.start = 1'b0;
    cyc();
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(a_if.busy), 64'd0);
    check_eq("mid_rst_cand", 64'(a_if.cand), 64'd0);
    check_eq("mid_rst_tries", 64'(a_if.tries), 64'd0);
    check_eq("mid_rst_vld", 64'(a_if.out_valid), 64'd0);
    check_eq("mid_rst_fail", 64'(a_if.fail), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    m_lfsr_b = 32'h1;
    check_eq("mid_rst_nofail", 64'(a_if.fail), 64'd0);
    a_first_run("after_rst");
    a_accept("after_rst");

    run_b(MTB + 1);
    run_b(3);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        b_seed(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      run_b($urandom_range(1, MTB + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
